// File: rtl/tmds_decoder_pkg.sv
// rtl/tmds_decoder_pkg.sv - shared TMDS control tokens and decoder FSM state type
//
// Purpose: the four 10-bit TMDS control tokens (also produced by the encoder)
// and the symbol-alignment FSM state encoding used by tmds_decoder.
// Ports: none (package).

package tmds_decoder_pkg;

  // Control-period tokens, full 10-bit symbol, bit 0 first on the wire.
  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP      = 2'd1,
    ST_SLIP_HOLD = 2'd2,
    ST_LOCKED    = 2'd3
  } state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational TMDS symbol classifier and data decoder
//
// Purpose: maps one 10-bit TMDS symbol to token flag, token value and the
// 8-bit data byte it would carry if it were a data symbol.
// Ports:
//   i_sym      in  10  TMDS symbol, bit 0 first on the wire
//   o_is_token out 1   symbol is one of the four control tokens
//   o_tok      out 2   {c1,c0} of the matched token (0 when not a token)
//   o_data     out 8   decoded data byte (meaningless for tokens)

module tmds_symbol_decode
  import tmds_decoder_pkg::*;
(
  input  logic [9:0] i_sym,
  output logic       o_is_token,
  output logic [1:0] o_tok,
  output logic [7:0] o_data
);

  logic [7:0] w_d;

  always_comb begin
    // Bit 9 flags DC-balance inversion; bit 8 selects XOR vs XNOR chaining.
    w_d    = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
    o_data = '0;
    o_data[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      o_data[i] = i_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    end
  end

  always_comb begin
    o_is_token = 1'b1;
    o_tok      = 2'b00;
    case (i_sym)
      TMDS_CTRL_00: o_tok = 2'b00;
      TMDS_CTRL_01: o_tok = 2'b01;
      TMDS_CTRL_10: o_tok = 2'b10;
      TMDS_CTRL_11: o_tok = 2'b11;
      default:      o_is_token = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS channel receiver: word alignment via bitslip and symbol decode
//
// Purpose: two-stage pipeline (classify, then output) plus an alignment FSM
// that requests bitslips until CTRL_RUN consecutive control tokens are seen.
// Ports:
//   clk_pix  in  1   pixel clock
//   rst_pix  in  1   synchronous active-high reset
//   sym_in   in  10  symbol from deserializer, one per cycle
//   bitslip  out 1   one-cycle request to shift the word boundary by one bit
//   locked   out 1   high while aligned
//   de       out 1   data enable
//   ctrl     out 2   decoded control bits {c1,c0}
//   dout     out 8   decoded data byte, 0 when de=0

module tmds_decoder
  import tmds_decoder_pkg::*;
#(
  parameter int SEARCH_LIMIT = 2048,
  parameter int CTRL_RUN     = 8,
  parameter int SLIP_WAIT    = 4,
  parameter int LOSS_LIMIT   = 4096
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic [9:0] sym_in,
  output logic       bitslip,
  output logic       locked,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] dout
);

  localparam int CNT_W = $clog2(LOSS_LIMIT) + 1;
  localparam int RUN_W = $clog2(CTRL_RUN + 1);

  logic             w_is_tok;
  logic [1:0]       w_tok;
  logic [7:0]       w_data;

  logic             r_is_tok;
  logic [1:0]       r_tok;
  logic [7:0]       r_data;

  state_t           r_state;
  logic [CNT_W-1:0] r_sym_cnt;
  logic [RUN_W-1:0] r_run_cnt;
  logic [RUN_W-1:0] w_run_inc;
  logic             w_run_full;

  tmds_symbol_decode u_dec (
    .i_sym      (sym_in),
    .o_is_token (w_is_tok),
    .o_tok      (w_tok),
    .o_data     (w_data)
  );

  // Run length including the symbol now in stage 1, so lock can be declared
  // on the very edge that moves the completing token into the output stage.
  always_comb begin
    w_run_inc = '0;
    if (r_is_tok) begin
      w_run_inc = (r_run_cnt == RUN_W'(CTRL_RUN)) ? r_run_cnt : r_run_cnt + 1'b1;
    end
    w_run_full = (w_run_inc == RUN_W'(CTRL_RUN));
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_is_tok  <= 1'b0;
      r_tok     <= 2'b00;
      r_data    <= 8'h00;
      r_state   <= ST_SEARCH;
      r_sym_cnt <= '0;
      r_run_cnt <= '0;
      bitslip   <= 1'b0;
      locked    <= 1'b0;
      de        <= 1'b0;
      ctrl      <= 2'b00;
      dout      <= 8'h00;
    end else begin
      r_is_tok <= w_is_tok;
      r_tok    <= w_tok;
      r_data   <= w_data;

      // Outputs default to the not-locked values; LOCKED overrides below.
      bitslip <= 1'b0;
      locked  <= 1'b0;
      de      <= 1'b0;
      ctrl    <= 2'b00;
      dout    <= 8'h00;

      case (r_state)
        ST_SEARCH: begin
          r_run_cnt <= w_run_inc;
          if (w_run_full) begin
            // Lock beats the search limit when both land together.
            r_state   <= ST_LOCKED;
            r_sym_cnt <= '0;
            locked    <= 1'b1;
            ctrl      <= r_tok;
          end else if (r_sym_cnt == CNT_W'(SEARCH_LIMIT - 1)) begin
            r_state   <= ST_SLIP;
            r_sym_cnt <= '0;
            r_run_cnt <= '0;
            bitslip   <= 1'b1;
          end else begin
            r_sym_cnt <= r_sym_cnt + 1'b1;
          end
        end

        ST_SLIP: begin
          r_state   <= ST_SLIP_HOLD;
          r_run_cnt <= '0;
        end

        ST_SLIP_HOLD: begin
          // Deserializer output is unreliable while it re-frames.
          r_run_cnt <= '0;
          if (r_sym_cnt == CNT_W'(SLIP_WAIT - 1)) begin
            r_state   <= ST_SEARCH;
            r_sym_cnt <= '0;
          end else begin
            r_sym_cnt <= r_sym_cnt + 1'b1;
          end
        end

        ST_LOCKED: begin
          if (!w_run_full && r_sym_cnt == CNT_W'(LOSS_LIMIT - 1)) begin
            // Drop back to searching; no slip until a full search fails.
            r_state   <= ST_SEARCH;
            r_sym_cnt <= '0;
            r_run_cnt <= '0;
          end else begin
            r_run_cnt <= w_run_inc;
            r_sym_cnt <= w_run_full ? '0 : r_sym_cnt + 1'b1;
            locked    <= 1'b1;
            if (r_is_tok) begin
              ctrl <= r_tok;
            end else begin
              de   <= 1'b1;
              dout <= r_data;
              ctrl <= ctrl;
            end
          end
        end

        default: r_state <= ST_SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - directed self-checking bench for tmds_decoder

module tb_tmds_decoder;

  logic       clk_pix = 1'b0;
  logic       rst_pix = 1'b0;
  logic [9:0] sym_in  = 10'h354;
  logic       bitslip;
  logic       locked;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] dout;

  int n_vec = 0;
  int n_bad = 0;

  tmds_decoder dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .sym_in  (sym_in),
    .bitslip (bitslip),
    .locked  (locked),
    .de      (de),
    .ctrl    (ctrl),
    .dout    (dout)
  );

  always #5 clk_pix = ~clk_pix;

  // Apply one symbol; returns #1 after the edge so outputs can be sampled.
  task automatic drive(input logic [9:0] s);
    sym_in = s;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic do_reset();
    rst_pix = 1'b1;
    drive(10'h354);
    drive(10'h354);
    rst_pix = 1'b0;
  endtask

  // Reference TMDS encoder (transmit side) for stream generation.
  function automatic logic [9:0] enc(input logic [7:0] b, input logic inv);
    logic [8:0] q;
    int n1;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(b[i]);
    q = '0;
    q[0] = b[0];
    if (n1 > 4 || (n1 == 4 && b[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ b[i]);
      q[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ b[i];
      q[8] = 1'b1;
    end
    return inv ? {1'b1, q[8], ~q[7:0]} : {1'b0, q};
  endfunction

  function automatic logic [7:0] src_byte(input int n);
    return 8'((n * 7 + 3) & 255);
  endfunction

  // Video line: 200 blanking tokens then 1366 data symbols.
  function automatic logic [9:0] stream_sym(input int n);
    if ((n % 1566) < 200) return 10'h354;
    return enc(src_byte(n), (n % 2) == 1);
  endfunction

  function automatic logic [9:0] word_at(input int bp);
    logic [9:0] w;
    logic [9:0] s;
    w = '0;
    for (int j = 0; j < 10; j++) begin
      s = stream_sym((bp + j) / 10);
      w[j] = s[(bp + j) % 10];
    end
    return w;
  endfunction

  task automatic test_reset();
    do_reset();
    n_vec++; if (bitslip !== 1'b0) begin n_bad++; $display("FAIL reset_bitslip got %b want 0", bitslip); end
    n_vec++; if (locked !== 1'b0)  begin n_bad++; $display("FAIL reset_locked got %b want 0", locked); end
    n_vec++; if (de !== 1'b0)      begin n_bad++; $display("FAIL reset_de got %b want 0", de); end
    n_vec++; if (ctrl !== 2'b00)   begin n_bad++; $display("FAIL reset_ctrl got %b want 00", ctrl); end
    n_vec++; if (dout !== 8'h00)   begin n_bad++; $display("FAIL reset_dout got %h want 00", dout); end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(10'h354);
      if (i == 8) begin
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early got %b want 0", locked); end
      end
      if (i == 9) begin
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_rise got %b want 1", locked); end
        n_vec++; if (ctrl !== 2'b00)  begin n_bad++; $display("FAIL lock_ctrl got %b want 00", ctrl); end
        n_vec++; if (de !== 1'b0)     begin n_bad++; $display("FAIL lock_de got %b want 0", de); end
      end
    end
    drive(10'h2AB);
    drive(10'h100);
    n_vec++; if (ctrl !== 2'b11)  begin n_bad++; $display("FAIL tok11_ctrl got %b want 11", ctrl); end
    n_vec++; if (de !== 1'b0)     begin n_bad++; $display("FAIL tok11_de got %b want 0", de); end
    n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL tok11_locked got %b want 1", locked); end
  endtask

  task automatic test_data();
    logic [9:0] syms  [6];
    logic [7:0] bytes [6];
    syms  = '{10'h100, 10'h0FF, 10'h1F0, 10'h39C, 10'h09C, 10'h3FF};
    bytes = '{8'h00, 8'hFF, 8'h10, 8'hA5, 8'h5A, 8'h00};
    // syms[0] was applied at the end of test_lock.
    for (int i = 1; i <= 6; i++) begin
      drive(i < 6 ? syms[i] : 10'h2AB);
      n_vec++; if (de !== 1'b1) begin n_bad++; $display("FAIL data_de[%0d] got %b want 1", i-1, de); end
      n_vec++; if (dout !== bytes[i-1]) begin n_bad++; $display("FAIL data_dout[%0d] got %h want %h", i-1, dout, bytes[i-1]); end
      n_vec++; if (ctrl !== 2'b11) begin n_bad++; $display("FAIL data_ctrl[%0d] got %b want 11", i-1, ctrl); end
    end
    drive(10'h2AB);
    n_vec++; if (de !== 1'b0)    begin n_bad++; $display("FAIL data_end_de got %b want 0", de); end
    n_vec++; if (dout !== 8'h00) begin n_bad++; $display("FAIL data_end_dout got %h want 00", dout); end
  endtask

  task automatic test_loss();
    int de_cnt;
    int slips;
    de_cnt = 0;
    slips  = 0;
    for (int i = 0; i < 10; i++) drive(10'h2AB);
    for (int c = 1; c <= 4098; c++) begin
      drive((c % 2) ? 10'h0FF : 10'h1F0);
      if (de === 1'b1) de_cnt++;
      if (bitslip === 1'b1) slips++;
      if (c == 4096) begin
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_hold got %b want 1", locked); end
      end
      if (c == 4097) begin
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL loss_drop got %b want 0", locked); end
      end
    end
    n_vec++; if (de_cnt !== 4095) begin n_bad++; $display("FAIL loss_de_count got %0d want 4095", de_cnt); end
    n_vec++; if (slips !== 0)     begin n_bad++; $display("FAIL loss_slips got %0d want 0", slips); end
    n_vec++; if (de !== 1'b0)     begin n_bad++; $display("FAIL loss_de got %b want 0", de); end
    n_vec++; if (dout !== 8'h00)  begin n_bad++; $display("FAIL loss_dout got %h want 00", dout); end
  endtask

  task automatic test_align();
    int bp;
    int slips;
    int checked;
    int c;
    int prev_idx;
    logic prev_aligned;
    logic seen_lock;
    do_reset();
    bp = 7;
    slips = 0;
    checked = 0;
    c = 0;
    prev_idx = 0;
    prev_aligned = 1'b0;
    seen_lock = 1'b0;
    while (checked < 300 && c < 20000) begin
      drive(word_at(bp));
      c++;
      if (locked === 1'b1) seen_lock = 1'b1;
      if (locked === 1'b1 && prev_aligned) begin
        if ((prev_idx % 1566) >= 200) begin
          n_vec++; if (de !== 1'b1 || dout !== src_byte(prev_idx)) begin
            n_bad++; $display("FAIL align_byte[%0d] got de=%b %h want de=1 %h", prev_idx, de, dout, src_byte(prev_idx));
          end
          checked++;
        end else begin
          n_vec++; if (de !== 1'b0 || ctrl !== 2'b00) begin
            n_bad++; $display("FAIL align_tok[%0d] got de=%b ctrl=%b want de=0 ctrl=00", prev_idx, de, ctrl);
          end
        end
      end
      prev_aligned = ((bp + 10) % 10) == 0;
      prev_idx     = bp / 10;
      // prev_* describes the word just applied; now advance the bit pointer.
      bp += 10;
      if (bitslip === 1'b1) begin
        slips++;
        bp += 1;
      end
    end
    n_vec++; if (checked < 300)     begin n_bad++; $display("FAIL align_timeout got %0d checks want 300", checked); end
    n_vec++; if (seen_lock !== 1'b1) begin n_bad++; $display("FAIL align_lock got %b want 1", seen_lock); end
    n_vec++; if (slips !== 3)       begin n_bad++; $display("FAIL align_slips got %0d want 3", slips); end
  endtask

  task automatic test_no_lock();
    int first;
    int second;
    int pulses;
    logic any_lock;
    do_reset();
    n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL nolock_reset got %b want 0", locked); end
    first = 0;
    second = 0;
    pulses = 0;
    any_lock = 1'b0;
    for (int c = 1; c <= 4200; c++) begin
      drive((c % 2) ? 10'h09C : 10'h39C);
      if (locked === 1'b1) any_lock = 1'b1;
      if (bitslip === 1'b1) begin
        pulses++;
        if (pulses == 1) first = c;
        if (pulses == 2) second = c;
      end
    end
    n_vec++; if (first !== 2048)  begin n_bad++; $display("FAIL nolock_first got %0d want 2048", first); end
    n_vec++; if (second !== 4101) begin n_bad++; $display("FAIL nolock_second got %0d want 4101", second); end
    n_vec++; if (pulses !== 2)    begin n_bad++; $display("FAIL nolock_pulses got %0d want 2", pulses); end
    n_vec++; if (any_lock !== 1'b0) begin n_bad++; $display("FAIL nolock_locked got %b want 0", any_lock); end
  endtask

  task automatic test_reset_hold();
    int slips;
    do_reset();
    for (int c = 1; c <= 2049; c++) drive(10'h0FF);
    rst_pix = 1'b1;
    drive(10'h0AB);
    rst_pix = 1'b0;
    n_vec++; if (bitslip !== 1'b0) begin n_bad++; $display("FAIL hold_rst_bitslip got %b want 0", bitslip); end
    n_vec++; if (locked !== 1'b0)  begin n_bad++; $display("FAIL hold_rst_locked got %b want 0", locked); end
    n_vec++; if (de !== 1'b0)      begin n_bad++; $display("FAIL hold_rst_de got %b want 0", de); end
    n_vec++; if (ctrl !== 2'b00)   begin n_bad++; $display("FAIL hold_rst_ctrl got %b want 00", ctrl); end
    n_vec++; if (dout !== 8'h00)   begin n_bad++; $display("FAIL hold_rst_dout got %h want 00", dout); end
    slips = 0;
    for (int i = 1; i <= 12; i++) begin
      drive(10'h0AB);
      if (bitslip === 1'b1) slips++;
      if (i == 8) begin
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL hold_lock_early got %b want 0", locked); end
      end
      if (i == 9) begin
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL hold_lock got %b want 1", locked); end
        n_vec++; if (ctrl !== 2'b01)  begin n_bad++; $display("FAIL hold_ctrl got %b want 01", ctrl); end
      end
    end
    n_vec++; if (slips !== 0) begin n_bad++; $display("FAIL hold_slips got %0d want 0", slips); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_data();
    test_loss();
    test_align();
    test_no_lock();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
